// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, legal oversampling ratios and
// the parity helper that the transmitter also uses.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    localparam int PAR_MAX_WD = 32;

    function automatic logic [5:0] norm_prescale(input logic [5:0] p);
        case (p)
            PRESCALE_8, PRESCALE_16, PRESCALE_32: return p;
            default:                              return PRESCALE_8;
        endcase
    endfunction

    // Zero-extending a narrower word does not change its parity.
    function automatic logic parity_bit(input logic [PAR_MAX_WD-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit timing for the receiver: edge counter, bit-end strobe and a
// 3-sample majority vote taken around the middle of each bit.
module uart_rx_sampler (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [5:0] prescale_i,
    input  logic       start_i,
    input  logic       run_i,
    input  logic       rx_i,
    output logic       bit_end_o,
    output logic       vote_o,
    output logic       vote_rdy_o
);
    logic [5:0] cnt_q, cnt_d;
    logic [5:0] half;
    logic [2:0] smp_q;

    assign half       = {1'b0, prescale_i[5:1]};
    assign bit_end_o  = run_i && (cnt_q == prescale_i - 6'd1);
    assign vote_rdy_o = run_i && (cnt_q == half + 6'd2);
    assign vote_o     = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);

    // The start-detect cycle is edge 0, so the counter is loaded with 1.
    always_comb begin
        cnt_d = cnt_q;
        if (start_i)
            cnt_d = 6'd1;
        else if (!run_i || bit_end_o)
            cnt_d = 6'd0;
        else
            cnt_d = cnt_q + 6'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 6'd0;
            smp_q <= 3'b111;
        end else begin
            cnt_q <= cnt_d;
            if (cnt_q == half - 6'd1) smp_q[0] <= rx_i;
            if (cnt_q == half)        smp_q[1] <= rx_i;
            if (cnt_q == half + 6'd1) smp_q[2] <= rx_i;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizes RX_IN, walks start/data/parity/stop bits and
// reports each frame as a data-valid, parity-error or stop-error pulse.
module uart_rx #(
    parameter int DATA_WD = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RX_IN,
    input  logic [5:0]         PRESCALE,
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
    output logic [DATA_WD-1:0] P_DATA,
    output logic               DATA_VALID,
    output logic               PAR_ERR,
    output logic               STP_ERR,
    output logic               Busy
);
    import uart_pkg::*;

    localparam int            BW       = (DATA_WD > 1) ? $clog2(DATA_WD) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WD - 1);

    logic               sync1_q, rx_s_q;
    rx_state_e          state_q;
    logic [5:0]         pscale_q;
    logic               par_en_q, par_typ_q, par_bad_q;
    logic [DATA_WD-1:0] shift_q;
    logic [BW-1:0]      bit_cnt_q;
    logic               start_det, run, bit_end, vote, vote_rdy;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= RX_IN;
            rx_s_q  <= sync1_q;
        end
    end

    assign start_det = (state_q == ST_IDLE) && !rx_s_q;
    assign run       = (state_q != ST_IDLE);

    uart_rx_sampler u_sampler (
        .clk_i      (CLK),
        .rst_ni     (RST),
        .prescale_i (pscale_q),
        .start_i    (start_det),
        .run_i      (run),
        .rx_i       (rx_s_q),
        .bit_end_o  (bit_end),
        .vote_o     (vote),
        .vote_rdy_o (vote_rdy)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            pscale_q   <= PRESCALE_8;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_bad_q  <= 1'b0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
            Busy       <= 1'b0;
        end else begin
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_det) begin
                        state_q   <= ST_START;
                        Busy      <= 1'b1;
                        pscale_q  <= norm_prescale(PRESCALE);
                        par_en_q  <= PAR_EN;
                        par_typ_q <= PAR_TYP;
                        par_bad_q <= 1'b0;
                        bit_cnt_q <= '0;
                    end
                end
                ST_START: begin
                    // A start bit that votes high was a glitch on an idle line.
                    if (vote_rdy && vote) begin
                        state_q <= ST_IDLE;
                        Busy    <= 1'b0;
                    end else if (bit_end) begin
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        shift_q   <= {vote, shift_q[DATA_WD-1:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LAST_BIT)
                            state_q <= par_en_q ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        par_bad_q <= (vote != parity_bit(PAR_MAX_WD'(shift_q), par_typ_q));
                        state_q   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        state_q <= ST_IDLE;
                        Busy    <= 1'b0;
                        STP_ERR <= !vote;
                        PAR_ERR <= par_bad_q;
                        if (vote && !par_bad_q) begin
                            P_DATA     <= shift_q;
                            DATA_VALID <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames with literal expectations
// plus randomized frames checked every cycle against a frame-level model.
module tb_uart_rx;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic [5:0] PRESCALE = 6'd8;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [7:0] P_DATA;
    logic       DATA_VALID, PAR_ERR, STP_ERR, Busy;

    uart_rx #(.DATA_WD(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PRESCALE   (PRESCALE),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_ERR    (PAR_ERR),
        .STP_ERR    (STP_ERR),
        .Busy       (Busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int       due;
        int       bfrom;
        int       bto;
        bit       dv;
        bit       pe;
        bit       se;
        bit [7:0] data;
    } exp_t;

    exp_t     q[$];
    bit [7:0] model_pdata = 8'h00;
    int       checks = 0;
    int       errors = 0;
    int       cyc = 0;
    int       pulse_cyc = -1;
    bit       pulse_dv, pulse_pe, pulse_se;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Expected outputs for the cycle just ended: pulses only at a frame's due
    // cycle, Busy inside the frame's busy window, P_DATA = last good byte.
    task automatic compare();
        bit edv = 1'b0, epe = 1'b0, ese = 1'b0, eb = 1'b0;
        if (!RST) begin
            q.delete();
            model_pdata = 8'h00;
        end else if (q.size() > 0) begin
            eb = (cyc >= q[0].bfrom) && (cyc <= q[0].bto);
            if (cyc == q[0].due) begin
                edv = q[0].dv;
                epe = q[0].pe;
                ese = q[0].se;
                if (q[0].dv) model_pdata = q[0].data;
                void'(q.pop_front());
            end
        end
        chk("DATA_VALID", DATA_VALID, edv);
        chk("PAR_ERR", PAR_ERR, epe);
        chk("STP_ERR", STP_ERR, ese);
        chk("Busy", Busy, eb);
        chk("P_DATA", P_DATA, model_pdata);
        if (DATA_VALID || PAR_ERR || STP_ERR) begin
            pulse_cyc = cyc;
            pulse_dv  = DATA_VALID;
            pulse_pe  = PAR_ERR;
            pulse_se  = STP_ERR;
        end
    endtask

    task automatic step(input logic v);
        RX_IN = v;
        @(posedge CLK);
        cyc++;
        @(negedge CLK);
        compare();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1);
    endtask

    // cut >= 0 stops half-way through bit index cut; gbit flips the middle
    // oversample of that bit, which the majority vote must reject.
    task automatic send_frame(input bit [7:0] d, input logic [5:0] ps, input bit pen,
                              input bit ptyp, input bit flip, input bit stop,
                              input int cut, input int gbit, output int t0);
        int     p, n;
        bit     bits[11];
        logic   v;
        exp_t   e;
        p = (ps == 6'd8 || ps == 6'd16 || ps == 6'd32) ? int'(ps) : 8;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        n = 9;
        if (pen) begin
            bits[9] = ($countones(d) % 2 == 1) ^ ptyp ^ flip;
            n = 10;
        end
        bits[n] = stop;
        n++;
        PRESCALE = ps;
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        t0       = cyc + 1;
        e.bfrom  = t0 + 2;
        e.bto    = t0 + n * p;
        e.due    = t0 + n * p + 1;
        e.dv     = stop && !(pen && flip);
        e.pe     = pen && flip;
        e.se     = !stop;
        e.data   = d;
        q.push_back(e);
        for (int b = 0; b < n; b++) begin
            for (int j = 0; j < p; j++) begin
                if (b == cut && j == p / 2) return;
                v = bits[b];
                if (b == gbit && j == p / 2) v = ~v;
                step(v);
                if (b == 1 && j == 0) begin
                    PRESCALE = 6'($urandom);
                    PAR_EN   = 1'($urandom);
                    PAR_TYP  = 1'($urandom);
                end
            end
        end
    endtask

    task automatic send_glitch(input int len, input logic [5:0] ps);
        exp_t e;
        int   t0;
        PRESCALE = ps;
        t0       = cyc + 1;
        e.bfrom  = t0 + 2;
        e.bto    = t0 + int'(ps) / 2 + 3;
        e.due    = e.bto + 1;
        e.dv     = 1'b0;
        e.pe     = 1'b0;
        e.se     = 1'b0;
        e.data   = 8'h00;
        q.push_back(e);
        repeat (len) step(1'b0);
    endtask

    initial begin
        int t0;
        @(negedge CLK);
        repeat (3) step(1'b1);
        chk("reset_pdata", P_DATA, 8'h00);
        chk("reset_busy", Busy, 1'b0);
        RST = 1'b1;
        idle(4);

        // 1: latency 2 + 10*8 edges from the first low sample
        send_frame(8'hA3, 6'd8, 0, 0, 0, 1, -1, -1, t0);
        idle(4);
        chk("t1_latency", pulse_cyc + 1 - t0, 82);
        chk("t1_pdata", P_DATA, 8'hA3);
        chk("t1_flags", {pulse_dv, pulse_pe, pulse_se}, 3'b100);

        // 2: even and odd parity, correct parity bits
        send_frame(8'hB4, 6'd8, 1, 0, 0, 1, -1, -1, t0);
        idle(4);
        chk("t2_even_pdata", P_DATA, 8'hB4);
        send_frame(8'hD2, 6'd8, 1, 1, 0, 1, -1, -1, t0);
        idle(4);
        chk("t2_odd_pdata", P_DATA, 8'hD2);
        chk("t2_latency", pulse_cyc + 1 - t0, 90);

        // 3: wrong parity bit keeps the previous byte
        send_frame(8'hB4, 6'd8, 1, 0, 0, 1, -1, -1, t0);
        send_frame(8'hB4, 6'd8, 1, 0, 1, 1, -1, -1, t0);
        idle(4);
        chk("t3_flags", {pulse_dv, pulse_pe, pulse_se}, 3'b010);
        chk("t3_pdata", P_DATA, 8'hB4);

        // 4: back-to-back at 16x, second frame with a bad stop bit
        send_frame(8'h5A, 6'd16, 0, 0, 0, 1, -1, -1, t0);
        send_frame(8'hC3, 6'd16, 0, 0, 0, 0, -1, -1, t0);
        idle(4);
        chk("t4_flags", {pulse_dv, pulse_pe, pulse_se}, 3'b001);
        chk("t4_pdata", P_DATA, 8'h5A);

        // 5: short low glitch is not a frame
        send_glitch(3, 6'd16);
        idle(16);
        chk("t5_busy_idle", Busy, 1'b0);
        send_frame(8'h81, 6'd16, 0, 0, 0, 1, -1, -1, t0);
        idle(4);
        chk("t5_pdata", P_DATA, 8'h81);

        // 6: reset during data bit 4 of 8'hFF
        send_frame(8'hFF, 6'd8, 0, 0, 0, 1, 5, -1, t0);
        chk("t6_busy_before", Busy, 1'b1);
        #2 RST = 1'b0;
        #1;
        chk("t6_rst_pdata", P_DATA, 8'h00);
        chk("t6_rst_busy", Busy, 1'b0);
        chk("t6_rst_pulses", {DATA_VALID, PAR_ERR, STP_ERR}, 3'b000);
        @(negedge CLK);
        compare();
        idle(3);
        RST = 1'b1;
        idle(40);
        send_frame(8'h3C, 6'd8, 0, 0, 0, 1, -1, -1, t0);
        idle(4);
        chk("t6_pdata", P_DATA, 8'h3C);

        // randomized frames: formats, illegal ratios, parity/stop errors,
        // single-sample glitches and back-to-back spacing
        for (int k = 0; k < 40; k++) begin
            logic [5:0] ps;
            int         r;
            r = int'($urandom_range(0, 7));
            case (r)
                0, 1:    ps = 6'd8;
                2, 3:    ps = 6'd16;
                4:       ps = 6'd32;
                5:       ps = 6'd0;
                6:       ps = 6'd12;
                default: ps = 6'd63;
            endcase
            send_frame(8'($urandom), ps, 1'($urandom), 1'($urandom),
                       ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) != 0),
                       -1, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 10)) : -1, t0);
            if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 20)));
        end
        idle(10);
        chk("model_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver: the downstream stage that consumes the serial TX_OUT stream of UART_TX_Top.
- Oversamples RX_IN at a runtime-selectable prescale and recovers start, data, optional parity and stop bits.
- Presents each received byte on a parallel bus with a one-cycle valid pulse.
- Flags parity and stop (framing) errors.
- The frame format matches the transmitter: start(0), DATA_WD bits LSB first, optional parity, stop(1).

Parameters:
DATA_WD, 8, number of data bits per frame.

Ports:
CLK  input  1  oversampling clock; all logic on its rising edge.
RST  input  1  asynchronous, active-low reset.
RX_IN  input  1  serial line, idle high, asynchronous to CLK.
PRESCALE  input  6  oversampling ratio in CLK cycles per bit; legal values 8, 16, 32.
PAR_EN  input  1  1 = a parity bit is present.
PAR_TYP  input  1  0 = even parity, 1 = odd parity.
P_DATA  output  DATA_WD  last correctly received byte.
DATA_VALID  output  1  one-cycle pulse when P_DATA updates.
PAR_ERR  output  1  one-cycle pulse: parity mismatch.
STP_ERR  output  1  one-cycle pulse: stop bit sampled 0.
Busy  output  1  high while a frame is being received.

Behaviour:
- Reset (RST=0, async): all outputs 0, FSM to IDLE, counters 0, synchronizer flops 1.
- Input path: RX_IN passes through a 2-flop synchronizer (reset value 1). All decisions use the synchronized signal rx_s.
- Configuration latch: PRESCALE, PAR_EN and PAR_TYP are latched on the IDLE->START transition. Changes mid-frame are ignored.
- Illegal PRESCALE (anything other than 8/16/32) is treated as 8.
- Edge counter: edge_cnt runs 0..P-1 within each bit period and wraps to 0 at P-1, advancing the bit counter.
- Sampling: rx_s is captured at edge_cnt = P/2-1, P/2 and P/2+1. The bit value is the majority of the 3 samples, resolved by edge_cnt = P/2+2.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: Busy=0. rx_s=0 -> START, edge_cnt=1; the detect cycle counts as edge 0.
  - START: if the majority value is 1 -> glitch, return to IDLE at edge_cnt = P/2+2 with no output pulses. Otherwise stay until edge_cnt = P-1, then go to DATA.
  - DATA: shift DATA_WD majority bits LSB first into a shift register. After bit DATA_WD-1 -> PARITY if PAR_EN=1, else STOP.
  - PARITY: expected bit = ^data (even) or ~^data (odd). A mismatch is recorded. At bit end -> STOP.
  - STOP: at edge_cnt = P-1, evaluate the frame and return to IDLE.
- Frame evaluation (end of STOP):
  - Stop majority 0 -> STP_ERR=1.
  - Parity mismatch recorded -> PAR_ERR=1.
  - Both errors may pulse in the same cycle.
  - No errors -> P_DATA <= shift register and DATA_VALID=1.
  - On any error, P_DATA holds its previous value and DATA_VALID stays 0.
- Pulse timing: DATA_VALID, PAR_ERR and STP_ERR are registered and high for exactly 1 cycle. That cycle is 2 + N*P CLK edges after the first edge at which RX_IN is sampled low, where N = 10 without parity and 11 with parity. The 2 is synchronizer latency.
- Busy: 1 from the IDLE->START transition through the cycle the FSM returns to IDLE. It drops to 0 in the same cycle the pulses are asserted.
- Back-to-back frames: if rx_s=0 in the first IDLE cycle after STOP, START is entered immediately. No idle bit is required beyond the stop bit.
- Reset mid-frame: the frame is discarded immediately and no pulse is produced. After release, reception resumes on the next falling edge.
- Break condition (line held low): STOP samples 0 -> STP_ERR pulses, then the FSM re-enters START from IDLE. The resulting frame also fails, until the line returns high.

Decomposition:
- Shared package uart_pkg: FSM state encoding (IDLE/START/DATA/PARITY/STOP), legal PRESCALE constants (8/16/32), and a parity function also used by UART_TX_Top.
- One sub-module, uart_rx_sampler: edge counter, bit-end strobe and 3-sample majority vote.
- uart_rx contains the synchronizer, FSM, shift register, parity/stop checks and output registers.

Test Plan:
1. PRESCALE=8, PAR_EN=0, frame carrying 8'hA3 -> single DATA_VALID with P_DATA=8'hA3, 82 cycles after the start edge; PAR_ERR=STP_ERR=0.
2. PRESCALE=8, even parity, 8'hB4 with parity bit 0 -> DATA_VALID, P_DATA=8'hB4. Repeat with odd parity, 8'hD2, parity bit 1 -> P_DATA=8'hD2.
3. Even parity, 8'hB4 sent with parity bit 1 -> PAR_ERR pulse only; no DATA_VALID; P_DATA keeps the prior value 8'hB4.
4. PRESCALE=16, no parity, 8'h5A then 8'hC3 back-to-back, stop bit 0 on the second frame -> DATA_VALID with 8'h5A, then STP_ERR only; P_DATA stays 8'h5A.
5. RX_IN low for 3 cycles then high (PRESCALE=16) -> no pulses; Busy goes high then returns to 0 by edge 10. A valid 8'h81 sent immediately after -> DATA_VALID, P_DATA=8'h81.
6. RST asserted during data bit 4 of 8'hFF -> all outputs 0 at once; no pulse for that frame. A following 8'h3C is received correctly.
